// File: rtl/preg_pkg.sv
// preg_pkg: shared constants, types and pointer helpers for the physical-register free list.
package preg_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {FL_INIT, FL_RUN} fl_state_t;
  function automatic logic [1:0] pop2(logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction
  function automatic ptr_t ptr_add(ptr_t p, logic [1:0] k);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W + 1)'(k);
    return (s >= (PTR_W + 1)'(DEPTH)) ? ptr_t'(s - (PTR_W + 1)'(DEPTH)) : ptr_t'(s);
  endfunction
endpackage

// File: rtl/preg_free_list_if.sv
// preg_free_list_if: rename-side allocate and retire-side release bundle of the free list.
interface preg_free_list_if;
  import preg_pkg::*;
  logic ready;
  logic [1:0] alloc_req;
  logic alloc_gnt;
  preg_t alloc_preg0;
  preg_t alloc_preg1;
  logic [1:0] rel_vld;
  preg_t rel_preg0;
  preg_t rel_preg1;
  cnt_t free_cnt;
  logic err;
  modport master (
    output alloc_req, rel_vld, rel_preg0, rel_preg1,
    input ready, alloc_gnt, alloc_preg0, alloc_preg1, free_cnt, err
  );
  modport slave (
    input alloc_req, rel_vld, rel_preg0, rel_preg1,
    output ready, alloc_gnt, alloc_preg0, alloc_preg1, free_cnt, err
  );
endinterface

// File: rtl/preg_inuse_chk.sv
// preg_inuse_chk: in-use bitmap that filters double frees and same-cycle duplicate releases.
module preg_inuse_chk
  import preg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic [1:0] rel_vld,
  input  preg_t rel_preg0,
  input  preg_t rel_preg1,
  input  logic [1:0] rel_wr,
  input  logic [1:0] alloc_set,
  input  preg_t alloc_preg0,
  input  preg_t alloc_preg1,
  output logic [1:0] acc,
  output logic df_err
);
  localparam logic [NUM_PREGS-1:0] INIT_MAP = {{DEPTH{1'b0}}, {NUM_AREGS{1'b1}}};
  logic [NUM_PREGS-1:0] inuse, inuse_next;
  logic same;
  assign same = rel_vld == 2'b11 && rel_preg0 == rel_preg1;
  assign acc[0] = rel_vld[0] && inuse[rel_preg0];
  assign acc[1] = rel_vld[1] && inuse[rel_preg1] && !same;
  assign df_err = (rel_vld[0] && !inuse[rel_preg0]) || (rel_vld[1] && !inuse[rel_preg1]) || same;
  always_comb begin
    inuse_next = inuse;
    if (alloc_set[0]) inuse_next[alloc_preg0] = 1'b1;
    if (alloc_set[1]) inuse_next[alloc_preg1] = 1'b1;
    if (rel_wr[0]) inuse_next[rel_preg0] = 1'b0;
    if (rel_wr[1]) inuse_next[rel_preg1] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inuse <= INIT_MAP;
    else inuse <= load ? INIT_MAP : inuse_next;
endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: circular free-preg FIFO, 2 allocs + 2 releases per cycle, self-filling after reset.
// PREG_FL_CHECK_EN adds in-use bitmap double-free detection.
module preg_free_list
  import preg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  preg_free_list_if.slave bus
);
  fl_state_t state, state_next;
  ptr_t fill_idx, head, tail;
  cnt_t count, taken;
  preg_t mem [DEPTH];
  logic run, gnt, ovf, df_err, err_q;
  logic [1:0] n, acc, wr;
  logic [CNT_W:0] sum;
  assign run = state == FL_RUN;
  assign n = pop2(bus.alloc_req);
  assign gnt = run && n != 2'd0 && count >= cnt_t'(n);
  assign taken = gnt ? cnt_t'(n) : '0;
  assign sum = {1'b0, count} - {1'b0, taken} + (CNT_W + 1)'(pop2(acc));
  assign ovf = sum > (CNT_W + 1)'(DEPTH);
  // an overflowing cycle drops every release but still honours the allocation
  assign wr = (run && !ovf) ? acc : 2'b00;
  always_comb begin
    state_next = (state == FL_INIT && fill_idx == ptr_t'(DEPTH - 1)) ? FL_RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FL_INIT;
      fill_idx <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (!run) begin
        fill_idx <= fill_idx + 1'b1;
        count <= (state_next == FL_RUN) ? cnt_t'(DEPTH) : '0;
      end else begin
        head <= ptr_add(head, gnt ? n : 2'd0);
        tail <= ptr_add(tail, pop2(wr));
        count <= ovf ? count - taken : cnt_t'(sum);
        err_q <= err_q | ovf | df_err;
      end
    end
  always_ff @(posedge clk) begin
    if (!run) mem[fill_idx] <= preg_t'(NUM_AREGS) + preg_t'(fill_idx);
    if (wr[0]) mem[tail] <= bus.rel_preg0;
    if (wr[1]) mem[wr[0] ? ptr_add(tail, 2'd1) : tail] <= bus.rel_preg1;
  end
  assign bus.ready = run;
  assign bus.alloc_gnt = gnt;
  assign bus.alloc_preg0 = gnt ? mem[head] : '0;
  assign bus.alloc_preg1 = gnt ? mem[bus.alloc_req[0] ? ptr_add(head, 2'd1) : head] : '0;
  assign bus.free_cnt = count;
  assign bus.err = err_q;
`ifdef PREG_FL_CHECK_EN
  preg_inuse_chk u_chk (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == FL_INIT && fill_idx == '0),
    .rel_vld(bus.rel_vld),
    .rel_preg0(bus.rel_preg0),
    .rel_preg1(bus.rel_preg1),
    .rel_wr(wr),
    .alloc_set(gnt ? bus.alloc_req : 2'b00),
    .alloc_preg0(bus.alloc_preg0),
    .alloc_preg1(bus.alloc_preg1),
    .acc(acc),
    .df_err(df_err)
  );
`else
  assign acc = bus.rel_vld;
  assign df_err = 1'b0;
`endif
endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list: directed stimulus with a per-cycle expectation queue drained by a negedge monitor.
module tb_preg_free_list;
  import preg_pkg::*;
`ifdef PREG_FL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {int rdy; int gnt; int p0; int p1; int cnt; int err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int vectors = 0;
  int fails = 0;
  always #5 clk = ~clk;
  preg_free_list_if bus();
  preg_free_list dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic cmp(string name, int act, int exp);
    if (exp >= 0) begin
      vectors++;
      if (act != exp) begin
        fails++;
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("ready", int'(bus.ready), e.rdy);
      cmp("alloc_gnt", int'(bus.alloc_gnt), e.gnt);
      cmp("alloc_preg0", int'(bus.alloc_preg0), e.p0);
      cmp("alloc_preg1", int'(bus.alloc_preg1), e.p1);
      cmp("free_cnt", int'(bus.free_cnt), e.cnt);
      cmp("err", int'(bus.err), e.err);
    end
  task automatic step(logic [1:0] req, logic [1:0] rv, int r0, int r1,
                      int rdy, int gnt, int p0, int p1, int cnt, int err);
    bus.alloc_req = req;
    bus.rel_vld = rv;
    bus.rel_preg0 = preg_t'(r0);
    bus.rel_preg1 = preg_t'(r1);
    q.push_back('{rdy, gnt, p0, p1, cnt, err});
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    bus.alloc_req = 2'b00;
    bus.rel_vld = 2'b00;
    bus.rel_preg0 = '0;
    bus.rel_preg1 = '0;
    @(posedge clk);
    #1;
    repeat (3) step(2'b11, 2'b11, 1, 2, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 1, 1, 32, -1, 32, 0);
    step(2'b11, 2'b00, 0, 0, 1, 1, 33, 34, 31, 0);
    step(2'b11, 2'b00, 0, 0, 1, 1, 35, 36, 29, 0);
    step(2'b10, 2'b00, 0, 0, 1, 1, -1, 37, 27, 0);
    for (int j = 0; j < 13; j++) step(2'b11, 2'b00, 0, 0, 1, 1, 38 + 2 * j, 39 + 2 * j, 26 - 2 * j, 0);
    step(2'b01, 2'b01, 5, 0, 1, 0, -1, -1, 0, 0);
    step(2'b01, 2'b00, 0, 0, 1, 1, 5, -1, 1, 0);
    for (int j = 0; j < 16; j++)
      step(2'b00, 2'b11, (40 + 2 * j) % 64, (41 + 2 * j) % 64, 1, 0, -1, -1, 2 * j, 0);
    for (int j = 0; j < 16; j++)
      step(2'b11, 2'b00, 0, 0, 1, 1, (40 + 2 * j) % 64, (41 + 2 * j) % 64, 32 - 2 * j, 0);
    step(2'b00, 2'b10, 0, 20, 1, 0, -1, -1, 0, 0);
    step(2'b11, 2'b11, 7, 9, 1, 0, -1, -1, 1, 0);
    step(2'b11, 2'b00, 0, 0, 1, 1, 20, 7, 3, 0);
    step(2'b01, 2'b01, 20, 0, 1, 1, 9, -1, 1, 0);
    step(2'b01, 2'b00, 0, 0, 1, 1, 20, -1, 1, 0);
    for (int j = 0; j < 16; j++) step(2'b00, 2'b11, 10 + 2 * j, 11 + 2 * j, 1, 0, -1, -1, 2 * j, 0);
    step(2'b00, 2'b01, 0, 0, 1, 0, -1, -1, 32, 0);
    step(2'b00, 2'b00, 0, 0, 1, 0, -1, -1, 32, 1);
    step(2'b01, 2'b11, 1, 2, 1, 1, 10, -1, 32, 1);
    step(2'b01, 2'b00, 0, 0, 1, 1, 11, -1, 31, 1);
    step(2'b00, 2'b00, 0, 0, 1, 0, -1, -1, 30, 1);
    rst_n = 1'b0;
    step(2'b11, 2'b11, 3, 4, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (10) step(2'b11, 2'b11, 3, 4, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(2'b11, 2'b11, 3, 4, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (32) step(2'b11, 2'b11, 3, 4, 0, 0, 0, 0, 0, 0);
    step(2'b00, 2'b00, 0, 0, 1, 0, -1, -1, 32, 0);
    step(2'b01, 2'b00, 0, 0, 1, 1, 32, -1, 32, 0);
    step(2'b00, 2'b01, 40, 0, 1, 0, -1, -1, 31, 0);
    step(2'b00, 2'b00, 0, 0, 1, 0, -1, -1, CHK ? 31 : 32, CHK ? 1 : 0);
    step(2'b01, 2'b00, 0, 0, 1, 1, 33, -1, CHK ? 31 : 32, CHK ? 1 : 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list controller for the out-of-order core. Sits beside the rename stage and hands out free physical registers to up to two renamed instructions per cycle. Takes back physical registers released by retire, up to two per cycle. Owns the free-pool state: after reset, p0..p(NUM_AREGS-1) are architecturally mapped and the remaining registers are free.

## Interface
- NUM_PREGS, 64, number of physical registers
- NUM_AREGS, 32, number of architectural registers, all mapped at reset
- PREG_W, 6, physical register index width, $clog2(NUM_PREGS)
- Derived: DEPTH = NUM_PREGS-NUM_AREGS (32); CNT_W = $clog2(DEPTH+1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ready  out  1  free list initialised; requests are accepted only when 1
- alloc_req  in  2  bit i = rename slot i needs a destination preg this cycle
- alloc_gnt  out  1  all requested slots served this cycle (all-or-nothing)
- alloc_preg0  out  PREG_W  preg for slot 0
- alloc_preg1  out  PREG_W  preg for slot 1
- rel_vld  in  2  bit i = retire port i releases rel_preg i
- rel_preg0  in  PREG_W  released preg, port 0
- rel_preg1  in  PREG_W  released preg, port 1
- free_cnt  out  CNT_W  current number of free pregs
- err  out  1  sticky error flag, cleared only by reset

## Operation
- Circular FIFO of DEPTH entries, with head (read) pointer, tail (write) pointer, and count; both pointers wrap modulo DEPTH.
- FSM states:
  - FL_INIT (reset state): fill_idx steps 0..DEPTH-1, writing NUM_AREGS+fill_idx into entry fill_idx, one per cycle. After the last write: head=0, tail=0, count=DEPTH, go to FL_RUN.
  - FL_RUN: normal operation; no exit except reset.
- In FL_INIT: alloc_req and rel_vld are ignored; ready=0; alloc_gnt=0.
- Allocation in FL_RUN:
  - n = popcount(alloc_req).
  - alloc_gnt = (n>0) && (count>=n), combinational.
  - If alloc_req==11: slot0 gets entry[head], slot1 gets entry[head+1].
  - If alloc_req==10: slot1 gets entry[head].
  - On grant, head advances by n at the clock edge.
  - With no grant, nothing is popped and the alloc_preg outputs are don't-care.
- Release in FL_RUN:
  - r = popcount(rel_vld).
  - Port 0 is written at tail, port 1 after it (at tail if only port 1 is valid); tail advances by r.
- Count update: count_next = count - (gnt?n:0) + r, for simultaneous allocate and release.
- Overflow: if count - (gnt?n:0) + r > DEPTH, set err, drop all releases that cycle, and still perform the allocation.
- Releases are not bypassed: entries written this cycle become allocatable next cycle.
- free_cnt = count.

## Timing
- Reset values (async on rst_n low): state FL_INIT, fill_idx 0, head 0, tail 0, count 0, ready 0, alloc_gnt 0, alloc_preg0/1 0, free_cnt 0, err 0.
- ready rises on the DEPTH-th rising edge after rst_n deasserts (32 cycles by default).
- Allocation is zero-latency: alloc_gnt and the pregs are valid in the request cycle, and the consuming edge is the same cycle's rising edge.
- Release-to-allocatable latency is 1 cycle.
- rst_n low mid-operation (including mid-INIT) aborts immediately, and the sequence restarts in FL_INIT.

## Configuration
- PREG_FL_CHECK_EN defined:
  - Adds an NUM_PREGS-bit in-use bitmap. It is set to 1 for p0..p(NUM_AREGS-1) and 0 otherwise, loaded in the first FL_INIT cycle.
  - A granted allocation sets the bit; an accepted release clears it.
  - A release of a preg whose bit is 0 (double free) sets err and drops that release only.
  - If both ports release the same preg in one cycle, err is set and port 1 is dropped.
- PREG_FL_CHECK_EN undefined: no bitmap; err reports overflow only, and double frees are pushed unchecked.

## Structure
- Shared package preg_pkg holds:
  - constants NUM_PREGS, NUM_AREGS, PREG_W
  - typedef preg_t (logic [PREG_W-1:0])
  - enum fl_state_t {FL_INIT, FL_RUN}
- One sub-module, preg_inuse_chk: the bitmap plus double-free detection. It is instantiated only under PREG_FL_CHECK_EN.

## Test plan
- Reset, then idle: ready=0 for 32 cycles, then ready=1 and free_cnt=32. alloc_req=01 gives gnt=1, preg0=32, and next-cycle free_cnt=31.
- Back-to-back alloc_req=11 for two cycles: (32,33) then (34,35), free_cnt 32→30→28. A single alloc_req=10 then gives preg1=36.
- Drain to free_cnt=0: alloc_req=01 gives gnt=0. In the same cycle rel_vld=01 with rel_preg0=5 gives free_cnt=1 the next cycle, and the next alloc gets 5.
- Wrap-around: allocate all 32, then release 40,41,…(32 values). Allocation must return them in release order across the pointer wrap.
- At free_cnt=1:
  - alloc_req=11 with rel_vld=11 (7,9) gives gnt=0 and free_cnt=3.
  - At free_cnt=32, rel_vld=01 gives err=1 (sticky) and free_cnt stays 32.
- rst_n pulsed low at INIT cycle 10: ready=0 and err=0 immediately, and ready rises again 32 cycles after release. Under PREG_FL_CHECK_EN, releasing an already-free preg 40 sets err and leaves free_cnt unchanged.
